// File: rtl/store_obuf.sv
// Buffer-RAM to AXI write-burst engine: reads I_len words from the local output
// buffer, streams them as one AXI write burst at I_base_addr, then waits for B.
module store_obuf #(
    parameter int C_M_AXI_LEN_WIDTH  = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_RAM_ADDR_WIDTH   = 10,
    parameter int C_RAM_DATA_WIDTH   = 128
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_raddr,
    output logic                          O_rd,
    input  logic [C_RAM_DATA_WIDTH-1:0]   I_rdata,
    output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_awlen,
    input  logic                          I_maxi_awready,
    output logic                          O_maxi_awvalid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_awaddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] O_maxi_wdata,
    output logic                          O_maxi_wvalid,
    input  logic                          I_maxi_wready,
    output logic                          O_maxi_wlast,
    output logic                          O_maxi_bready,
    input  logic                          I_maxi_bvalid
);
    localparam int CW = C_RAM_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, AW, DATA, RESP, DONE} state_t;

    state_t                          state_reg, state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   base_reg;
    logic [C_RAM_ADDR_WIDTH-1:0]     len_reg;
    logic [CW-1:0]                   rcnt_reg, wcnt_reg;
    logic [CW-1:0]                   len_ext, last_idx;
    logic                            inflight_reg;
    logic [1:0]                      occ_reg;
    logic                            wr_ptr_reg, rd_ptr_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]   head_data;
    logic                            push, pop, rd, wvalid, wlast, start_xfer;

    assign len_ext    = {1'b0, len_reg};
    assign last_idx   = len_ext - CW'(1);
    assign start_xfer = (state_reg == IDLE) && I_ap_start && (I_len != '0);

    assign push   = inflight_reg;
    assign wvalid = (state_reg == DATA) && (occ_reg != 2'd0);
    assign pop    = wvalid && I_maxi_wready;
    assign wlast  = wvalid && (wcnt_reg == last_idx);

    // Credit check counts the slot freed by a same-cycle pop, so a steady
    // stream of reads keeps the W channel at one beat per cycle.
    assign rd = (state_reg == DATA) && (rcnt_reg < len_ext) &&
                (({1'b0, occ_reg} + {2'b0, inflight_reg}) < (3'd2 + {2'b0, pop}));

    // Two-entry skid FIFO; each entry is its own register so the write
    // pointer simply selects which one captures the returning RAM word.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [C_M_AXI_DATA_WIDTH-1:0] entry_reg;
            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= I_rdata;
                end
            end
        end
    endgenerate

    assign head_data = rd_ptr_reg ? g_fifo[1].entry_reg : g_fifo[0].entry_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (I_ap_start) begin
                    state_next = (I_len != '0) ? AW : DONE;
                end
            end
            AW:      if (I_maxi_awready) state_next = DATA;
            DATA:    if (pop && wlast) state_next = RESP;
            RESP:    if (I_maxi_bvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            rcnt_reg     <= '0;
            wcnt_reg     <= '0;
            inflight_reg <= 1'b0;
            occ_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd;
            occ_reg      <= occ_reg + 2'(push) - 2'(pop);
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            if (start_xfer) begin
                base_reg <= I_base_addr;
                len_reg  <= I_len;
                rcnt_reg <= '0;
                wcnt_reg <= '0;
            end else begin
                if (rd)  rcnt_reg <= rcnt_reg + CW'(1);
                if (pop) wcnt_reg <= wcnt_reg + CW'(1);
            end
        end
    end

    assign O_ap_done      = (state_reg == DONE);
    assign O_raddr        = rcnt_reg[C_RAM_ADDR_WIDTH-1:0];
    assign O_rd           = rd;
    assign O_maxi_awvalid = (state_reg == AW);
    assign O_maxi_awaddr  = (state_reg == AW) ? base_reg : '0;
    assign O_maxi_awlen   = (state_reg == AW) ? C_M_AXI_LEN_WIDTH'(len_reg) : '0;
    assign O_maxi_wvalid  = wvalid;
    assign O_maxi_wdata   = wvalid ? head_data : '0;
    assign O_maxi_wlast   = wlast;
    assign O_maxi_bready  = (state_reg == RESP);

endmodule

// File: tb/tb_store_obuf.sv
// Bench for store_obuf: table of bursts with varied AXI back-pressure, plus
// hand-written zero-length, mid-burst reset and held-start sequences.
module tb_store_obuf;
    logic         I_clk = 1'b0;
    logic         I_rst = 1'b1;
    logic         I_ap_start = 1'b0;
    logic         O_ap_done;
    logic [31:0]  I_base_addr = '0;
    logic [9:0]   I_len = '0;
    logic [9:0]   O_raddr;
    logic         O_rd;
    logic [127:0] I_rdata = '0;
    logic [31:0]  O_maxi_awlen;
    logic         I_maxi_awready = 1'b0;
    logic         O_maxi_awvalid;
    logic [31:0]  O_maxi_awaddr;
    logic [127:0] O_maxi_wdata;
    logic         O_maxi_wvalid;
    logic         I_maxi_wready = 1'b0;
    logic         O_maxi_wlast;
    logic         O_maxi_bready;
    logic         I_maxi_bvalid = 1'b0;

    store_obuf dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_ap_start(I_ap_start), .O_ap_done(O_ap_done),
        .I_base_addr(I_base_addr), .I_len(I_len), .O_raddr(O_raddr), .O_rd(O_rd),
        .I_rdata(I_rdata), .O_maxi_awlen(O_maxi_awlen), .I_maxi_awready(I_maxi_awready),
        .O_maxi_awvalid(O_maxi_awvalid), .O_maxi_awaddr(O_maxi_awaddr),
        .O_maxi_wdata(O_maxi_wdata), .O_maxi_wvalid(O_maxi_wvalid),
        .I_maxi_wready(I_maxi_wready), .O_maxi_wlast(O_maxi_wlast),
        .O_maxi_bready(O_maxi_bready), .I_maxi_bvalid(I_maxi_bvalid)
    );

    always #5 I_clk = ~I_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [31:0] u;
        u = i;
        return {16'hA5C3, u[15:0], 32'h1234_5678 ^ (u * 32'd7), ~u, u * 32'h9E37_79B9};
    endfunction

    // Buffer RAM model with one-cycle registered read
    logic [127:0] ram [1024];
    initial for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    always @(posedge I_clk) if (O_rd) I_rdata <= ram[O_raddr];

    // AXI slave responder: ready/valid driven just after each rising edge
    int cyc = 0;
    int aw_delay = 0, wmode = 0, b_delay = 0;
    int aw_wait = 0, b_wait = 0;
    always @(posedge I_clk) begin
        cyc++;
        #1;
        if (O_maxi_awvalid) begin
            I_maxi_awready = (aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            I_maxi_awready = 1'b0;
            aw_wait = 0;
        end
        case (wmode)
            0:       I_maxi_wready = 1'b1;
            1:       I_maxi_wready = ((cyc % 3) == 0);
            default: I_maxi_wready = 1'($urandom_range(0, 1));
        endcase
        if (O_maxi_bready) begin
            I_maxi_bvalid = (b_wait >= b_delay);
            b_wait++;
        end else begin
            I_maxi_bvalid = 1'b0;
            b_wait = 0;
        end
    end

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;

    // Monitor state
    int aw_high_cycles = 0, aw_hs_count = 0, aw_rise_cycle = -1;
    logic [31:0] aw_hs_addr = '0, aw_hs_len = '0;
    logic aw_open = 1'b0;
    int reads_issued = 0, beats_seen = 0, xfer_beat = 0, last_beat_cyc = 0;
    int wvalid_cycles = 0, b_hs_count = 0, b_hs_cycle = -1;
    int done_count = 0, done_cycle = -1;
    logic b2b_check = 1'b0;
    logic prev_awvalid = 1'b0, prev_awready = 1'b0, prev_wvalid = 1'b0, prev_wready = 1'b0;
    logic prev_wlast = 1'b0;
    logic [31:0] prev_awaddr = '0, prev_awlen = '0;
    logic [127:0] prev_wdata = '0;

    always @(negedge I_clk) begin
        if (I_rst) begin
            prev_awvalid = 1'b0;
            prev_wvalid  = 1'b0;
        end else begin
            if (O_maxi_awvalid) begin
                aw_high_cycles++;
                if (prev_awvalid && !prev_awready) begin
                    check("aw_addr_stable", O_maxi_awaddr, prev_awaddr);
                    check("aw_len_stable", O_maxi_awlen, prev_awlen);
                end
                if (!prev_awvalid) aw_rise_cycle = cyc;
            end
            if (O_maxi_wvalid) begin
                wvalid_cycles++;
                check("w_after_aw", aw_open, 1'b1);
            end
            if (O_maxi_awvalid && I_maxi_awready) begin
                aw_hs_count++;
                aw_hs_addr = O_maxi_awaddr;
                aw_hs_len  = O_maxi_awlen;
                aw_open    = 1'b1;
            end
            if (prev_wvalid && !prev_wready) begin
                check("w_valid_held", O_maxi_wvalid, 1'b1);
                check("w_data_held", O_maxi_wdata, prev_wdata);
                check("w_last_held", O_maxi_wlast, prev_wlast);
            end
            if (O_rd) begin
                check("rd_credit",
                      ((reads_issued - beats_seen - ((O_maxi_wvalid && I_maxi_wready) ? 1 : 0)) < 2), 1'b1);
                reads_issued++;
            end
            if (O_maxi_wvalid && I_maxi_wready) begin
                if (exp_q.size() == 0) begin
                    check("beat_expected", 1'b0, 1'b1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w_data", O_maxi_wdata, mon_e.data);
                    check("w_last", O_maxi_wlast, mon_e.last);
                end
                if (b2b_check && xfer_beat > 0) check("w_b2b", cyc, last_beat_cyc + 1);
                last_beat_cyc = cyc;
                beats_seen++;
                xfer_beat++;
                if (O_maxi_wlast) begin
                    xfer_beat = 0;
                    aw_open   = 1'b0;
                end
            end
            if (O_maxi_bready && I_maxi_bvalid) begin
                b_hs_count++;
                b_hs_cycle = cyc;
            end
            if (O_ap_done) begin
                done_count++;
                done_cycle = cyc;
            end
            prev_awvalid = O_maxi_awvalid;
            prev_awready = I_maxi_awready;
            prev_awaddr  = O_maxi_awaddr;
            prev_awlen   = O_maxi_awlen;
            prev_wvalid  = O_maxi_wvalid;
            prev_wready  = I_maxi_wready;
            prev_wdata   = O_maxi_wdata;
            prev_wlast   = O_maxi_wlast;
        end
    end

    task automatic clear_stats();
        aw_high_cycles = 0; aw_hs_count = 0; reads_issued = 0; beats_seen = 0;
        xfer_beat = 0; wvalid_cycles = 0; b_hs_count = 0; aw_open = 1'b0;
    endtask

    task automatic push_expected(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = pat(i);
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    int start_cyc = 0;
    task automatic start_xfer(input logic [31:0] base, input int len);
        @(posedge I_clk); #2;
        I_base_addr = base;
        I_len       = 10'(len);
        I_ap_start  = 1'b1;
        start_cyc   = cyc;
        push_expected(len);
        @(posedge I_clk); #2;
        I_ap_start  = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string name);
        int t = 0;
        while (done_count <= prev && t < 3000) begin
            @(negedge I_clk);
            t++;
        end
        check(name, (done_count > prev), 1'b1);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_done"}, O_ap_done, 1'b0);
        check({name, "_rd"}, O_rd, 1'b0);
        check({name, "_raddr"}, O_raddr, 10'd0);
        check({name, "_awvalid"}, O_maxi_awvalid, 1'b0);
        check({name, "_awaddr"}, O_maxi_awaddr, 32'd0);
        check({name, "_awlen"}, O_maxi_awlen, 32'd0);
        check({name, "_wvalid"}, O_maxi_wvalid, 1'b0);
        check({name, "_wdata"}, O_maxi_wdata, 128'd0);
        check({name, "_wlast"}, O_maxi_wlast, 1'b0);
        check({name, "_bready"}, O_maxi_bready, 1'b0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          len;
        int          aw_delay;
        int          wmode;
        int          b_delay;
        logic [31:0] exp_awlen;
        int          exp_beats;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int d0, d1, t;
        vecs[0] = '{32'h0000_1000, 4,  0, 0, 0, 32'd4,  4};
        vecs[1] = '{32'h0000_2000, 6,  0, 1, 0, 32'd6,  6};
        vecs[2] = '{32'h0000_3000, 1,  5, 0, 0, 32'd1,  1};
        vecs[3] = '{32'h0000_4000, 16, 2, 2, 3, 32'd16, 16};
        vecs[4] = '{32'h0000_5000, 5,  0, 0, 2, 32'd5,  5};

        repeat (3) @(posedge I_clk);
        #2;
        check_outputs_zero("reset");
        I_rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            aw_delay  = vecs[v].aw_delay;
            wmode     = vecs[v].wmode;
            b_delay   = vecs[v].b_delay;
            b2b_check = (vecs[v].wmode == 0);
            clear_stats();
            d0 = done_count;
            start_xfer(vecs[v].base, vecs[v].len);
            wait_done(d0, "xfer_done");
            check("xfer_awaddr", aw_hs_addr, vecs[v].base);
            check("xfer_awlen", aw_hs_len, vecs[v].exp_awlen);
            check("xfer_aw_count", aw_hs_count, 1);
            check("xfer_beats", beats_seen, vecs[v].exp_beats);
            check("xfer_reads", reads_issued, vecs[v].exp_beats);
            check("xfer_done_after_b", done_cycle, b_hs_cycle + 1);
            check("xfer_q_empty", exp_q.size(), 0);
            if (vecs[v].aw_delay > 0)
                check("xfer_aw_held", (aw_high_cycles >= vecs[v].aw_delay + 1), 1'b1);
            repeat (3) @(negedge I_clk);
            check("xfer_done_once", done_count, d0 + 1);
            $display("xfer %0d base=%0h len=%0d beats=%0d done_cycle=%0d", v,
                     vecs[v].base, vecs[v].len, beats_seen, done_cycle);
        end

        // Zero-length start: straight to DONE with no AXI traffic
        aw_delay = 0; wmode = 0; b_delay = 0; b2b_check = 1'b1;
        clear_stats();
        d0 = done_count;
        start_xfer(32'h0000_9000, 0);
        wait_done(d0, "len0_done");
        check("len0_done_cycle", done_cycle, start_cyc + 1);
        check("len0_no_aw", aw_high_cycles, 0);
        check("len0_no_w", wvalid_cycles, 0);
        check("len0_no_rd", reads_issued, 0);
        $display("len0 start_cycle=%0d done_cycle=%0d", start_cyc, done_cycle);

        // Reset after the second beat of an 8-beat burst
        clear_stats();
        d0 = done_count;
        start_xfer(32'h0000_6000, 8);
        t = 0;
        while (beats_seen < 2 && t < 500) begin
            @(negedge I_clk);
            t++;
        end
        check("rst_reached_beat2", (beats_seen >= 2), 1'b1);
        @(posedge I_clk); #2;
        I_rst = 1'b1;
        @(posedge I_clk); #2;
        check_outputs_zero("abort");
        I_rst = 1'b0;
        exp_q.delete();
        clear_stats();
        repeat (4) @(negedge I_clk);
        check("abort_no_done", done_count, d0);
        check("abort_stays_idle", O_maxi_awvalid | O_maxi_wvalid | O_rd, 1'b0);
        d0 = done_count;
        start_xfer(32'h0000_7000, 2);
        wait_done(d0, "post_rst_done");
        check("post_rst_beats", beats_seen, 2);
        check("post_rst_awaddr", aw_hs_addr, 32'h0000_7000);
        check("post_rst_q_empty", exp_q.size(), 0);
        $display("abort+restart beats=%0d done_cycle=%0d", beats_seen, done_cycle);

        // ap_start held high: second start only taken once back in IDLE
        clear_stats();
        b2b_check = 1'b1;
        d0 = done_count;
        push_expected(3);
        push_expected(3);
        @(posedge I_clk); #2;
        I_base_addr = 32'h0000_8000;
        I_len       = 10'd3;
        I_ap_start  = 1'b1;
        wait_done(d0, "held_done1");
        d1 = done_cycle;
        check("held_aw_count1", aw_hs_count, 1);
        t = 0;
        while (aw_rise_cycle <= d1 && t < 100) begin
            @(negedge I_clk);
            t++;
        end
        check("held_restart_cycle", aw_rise_cycle, d1 + 2);
        I_ap_start = 1'b0;
        wait_done(d0 + 1, "held_done2");
        check("held_aw_count2", aw_hs_count, 2);
        check("held_beats", beats_seen, 6);
        check("held_q_empty", exp_q.size(), 0);
        repeat (4) @(negedge I_clk);
        check("held_done_total", done_count, d0 + 2);
        $display("held start done1=%0d restart_aw=%0d done2=%0d", d1, aw_rise_cycle, done_cycle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
